// File: rtl/uart_frame_pkg.sv
// Shared definitions for the UART receive framer.
//   state_t             : framer state machine encoding
//   ERR_*               : err_code values reported with frame_err
//   SYNC_BYTE_DEFAULT   : default frame start marker
package uart_frame_pkg;

  typedef enum logic [2:0] {
    S_SYNC,
    S_LEN,
    S_PAYLOAD,
    S_CHK,
    S_EMIT
  } state_t;

  localparam logic [1:0] ERR_LEN     = 2'd0;
  localparam logic [1:0] ERR_CHK     = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT = 2'd2;
  localparam logic [1:0] ERR_OVERRUN = 2'd3;

  localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

endpackage

// File: rtl/uart_rx_framer_if.sv
// Bundle of the framer's data-path and status signals.
//   rx_data/rx_valid          : byte strobe from the UART receiver
//   out_data/out_valid/out_ready/out_last : payload byte stream
//   frame_ok/frame_err/err_code/busy      : frame status
// slave  : the framer side
// master : the environment side (receiver + consumer)
interface uart_rx_framer_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       out_last;
  logic       frame_ok;
  logic       frame_err;
  logic [1:0] err_code;
  logic       busy;

  modport slave (
    input  rx_data, rx_valid, out_ready,
    output out_data, out_valid, out_last, frame_ok, frame_err, err_code, busy
  );

  modport master (
    output rx_data, rx_valid, out_ready,
    input  out_data, out_valid, out_last, frame_ok, frame_err, err_code, busy
  );
endinterface

// File: rtl/uart_rx_framer.sv
// Frame decoder downstream of a UART receiver. Hunts for SYNC_BYTE, reads a
// length byte, collects that many payload bytes and checks an XOR checksum
// (LEN ^ payload). Good payloads are replayed as a valid/ready stream with a
// last marker; bad, timed-out or overrun frames raise frame_err + err_code.
// Ports:
//   clk : system clock
//   rst : asynchronous active-high reset
//   bus : uart_rx_framer_if.slave (rx byte input, payload output, status)
module uart_rx_framer
  import uart_frame_pkg::*;
#(
  parameter int unsigned MAX_LEN        = 16,
  parameter int unsigned TIMEOUT_CYCLES = 100000,
  parameter logic [7:0]  SYNC_BYTE      = SYNC_BYTE_DEFAULT
) (
  input logic             clk,
  input logic             rst,
  uart_rx_framer_if.slave bus
);

  localparam int unsigned LW = $clog2(MAX_LEN + 1);
  localparam int unsigned AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int unsigned TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);

  state_t          state;
  logic [LW-1:0]   len;
  logic [LW-1:0]   idx;
  logic [7:0]      csum;
  logic [TW-1:0]   tcnt;
  logic [7:0]      buf_q [MAX_LEN];

  logic [7:0]      out_data;
  logic            out_valid;
  logic            out_last;
  logic            frame_ok;
  logic            frame_err;
  logic [1:0]      err_code;
  logic            busy;

  logic [LW-1:0]   idx_nxt;
  logic [LW-1:0]   last_idx;

  assign idx_nxt  = idx + LW'(1);
  assign last_idx = len - LW'(1);

  assign bus.out_data  = out_data;
  assign bus.out_valid = out_valid;
  assign bus.out_last  = out_last;
  assign bus.frame_ok  = frame_ok;
  assign bus.frame_err = frame_err;
  assign bus.err_code  = err_code;
  assign bus.busy      = busy;

  // Payload storage carries no reset; contents are only read after being written.
  always_ff @(posedge clk) begin
    if (state == S_PAYLOAD && bus.rx_valid) begin
      buf_q[idx[AW-1:0]] <= bus.rx_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_SYNC;
      len       <= '0;
      idx       <= '0;
      csum      <= '0;
      tcnt      <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      frame_ok  <= 1'b0;
      frame_err <= 1'b0;
      err_code  <= ERR_LEN;
      busy      <= 1'b0;
    end else begin
      frame_ok  <= 1'b0;
      frame_err <= 1'b0;
      unique case (state)
        S_SYNC: begin
          if (bus.rx_valid && bus.rx_data == SYNC_BYTE) begin
            state <= S_LEN;
            busy  <= 1'b1;
            tcnt  <= '0;
          end
        end
        S_LEN, S_PAYLOAD, S_CHK: begin
          // A byte takes priority over timeout expiry on the same cycle.
          if (bus.rx_valid) begin
            tcnt <= '0;
            if (state == S_LEN) begin
              if (bus.rx_data == '0 || 32'(bus.rx_data) > MAX_LEN) begin
                frame_err <= 1'b1;
                err_code  <= ERR_LEN;
                state     <= S_SYNC;
                busy      <= 1'b0;
              end else begin
                len   <= LW'(bus.rx_data);
                csum  <= bus.rx_data;
                idx   <= '0;
                state <= S_PAYLOAD;
              end
            end else if (state == S_PAYLOAD) begin
              csum <= csum ^ bus.rx_data;
              idx  <= idx_nxt;
              if (idx_nxt == len) begin
                state <= S_CHK;
              end
            end else begin
              if (bus.rx_data == csum) begin
                frame_ok  <= 1'b1;
                idx       <= '0;
                state     <= S_EMIT;
                out_valid <= 1'b1;
                out_data  <= buf_q[0];
                out_last  <= (len == LW'(1));
              end else begin
                frame_err <= 1'b1;
                err_code  <= ERR_CHK;
                state     <= S_SYNC;
                busy      <= 1'b0;
              end
            end
          end else if (tcnt == T_LAST) begin
            // Compare-before-increment: expiry lands TIMEOUT_CYCLES idle cycles after the last byte.
            frame_err <= 1'b1;
            err_code  <= ERR_TIMEOUT;
            state     <= S_SYNC;
            busy      <= 1'b0;
            tcnt      <= '0;
          end else begin
            tcnt <= tcnt + TW'(1);
          end
        end
        S_EMIT: begin
          if (bus.rx_valid) begin
            frame_err <= 1'b1;
            err_code  <= ERR_OVERRUN;
          end
          // out_data/out_last are pre-loaded for the next index so they are registered.
          if (out_valid && bus.out_ready) begin
            if (out_last) begin
              state     <= S_SYNC;
              busy      <= 1'b0;
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              out_data  <= '0;
              idx       <= '0;
            end else begin
              idx      <= idx_nxt;
              out_data <= buf_q[idx_nxt[AW-1:0]];
              out_last <= (idx_nxt == last_idx);
            end
          end
        end
        default: begin
          state <= S_SYNC;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_framer.sv
module tb_uart_rx_framer;

  localparam int unsigned MAXL = 16;
  localparam int unsigned TO   = 40;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  uart_rx_framer_if bus ();

  uart_rx_framer #(
    .MAX_LEN        (MAXL),
    .TIMEOUT_CYCLES (TO),
    .SYNC_BYTE      (8'hA5)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  logic [7:0] sent [$];
  logic [7:0] got_d [$];
  bit         got_l [$];
  logic [1:0] err_q [$];
  int         ok_cnt   = 0;
  int         both_cnt = 0;

  logic [7:0] exp_d [$];
  bit         exp_l [$];
  logic [1:0] exp_err [$];
  int         exp_ok;

  bit         stall_prev = 1'b0;
  logic [7:0] prev_d;
  bit         prev_l;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else n_pass++;
  endtask

  // Observe the output side between clock edges.
  always @(negedge clk) begin
    if (rst) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        check("stall_data", bus.out_data, prev_d);
        check("stall_last", bus.out_last, prev_l);
      end
      if (bus.out_valid && bus.out_ready) begin
        got_d.push_back(bus.out_data);
        got_l.push_back(bus.out_last);
      end
      if (bus.frame_ok) ok_cnt++;
      if (bus.frame_err) err_q.push_back(bus.err_code);
      if (bus.frame_ok && bus.frame_err) both_cnt++;
      stall_prev = bus.out_valid && !bus.out_ready;
      prev_d     = bus.out_data;
      prev_l     = bus.out_last;
    end
  end

  task automatic clear_mon();
    sent.delete();
    got_d.delete();
    got_l.delete();
    err_q.delete();
    ok_cnt = 0;
  endtask

  // Called at #1 after a clock edge; returns #1 after the edge that sampled the byte.
  task automatic send_byte(input logic [7:0] b, input bit log = 1'b1);
    bus.rx_valid = 1'b1;
    bus.rx_data  = b;
    if (log) sent.push_back(b);
    @(posedge clk);
    #1;
    bus.rx_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_idle(input bit rnd);
    bit done = 1'b0;
    for (int k = 0; k < 400 && !done; k++) begin
      if (rnd) bus.out_ready = 1'($urandom_range(0, 1));
      @(posedge clk);
      #1;
      if (!bus.busy && !bus.out_valid) done = 1'b1;
    end
    bus.out_ready = 1'b1;
    if (!done) check("wait_idle_bound", 0, 1);
    idle(2);
  endtask

  // Frame-level parse of the logged byte stream.
  task automatic run_model();
    int unsigned p = 0;
    int unsigned n = sent.size();
    int unsigned len;
    logic [7:0]  x;
    exp_d.delete();
    exp_l.delete();
    exp_err.delete();
    exp_ok = 0;
    while (p < n) begin
      if (sent[p] != 8'hA5) begin
        p++;
        continue;
      end
      p++;
      if (p >= n) break;
      len = sent[p];
      p++;
      if (len == 0 || len > MAXL) begin
        exp_err.push_back(2'd0);
        continue;
      end
      if (p + len >= n) break;
      x = 8'(len);
      for (int unsigned i = 0; i < len; i++) x ^= sent[p+i];
      if (sent[p+len] == x) begin
        for (int unsigned i = 0; i < len; i++) begin
          exp_d.push_back(sent[p+i]);
          exp_l.push_back(i == len - 1);
        end
        exp_ok++;
      end else begin
        exp_err.push_back(2'd1);
      end
      p += len + 1;
    end
  endtask

  task automatic compare_model(input string tag);
    run_model();
    check({tag, "_nbytes"}, got_d.size(), exp_d.size());
    check({tag, "_nok"}, ok_cnt, exp_ok);
    check({tag, "_nerr"}, err_q.size(), exp_err.size());
    for (int i = 0; i < got_d.size() && i < exp_d.size(); i++) begin
      check($sformatf("%s_data%0d", tag, i), got_d[i], exp_d[i]);
      check($sformatf("%s_last%0d", tag, i), got_l[i], exp_l[i]);
    end
    for (int i = 0; i < err_q.size() && i < exp_err.size(); i++)
      check($sformatf("%s_code%0d", tag, i), err_q[i], exp_err[i]);
  endtask

  task automatic send_list(input logic [7:0] b [$]);
    foreach (b[i]) send_byte(b[i]);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int hit;
    logic [7:0] fr [$];
    bus.rx_valid  = 1'b0;
    bus.rx_data   = '0;
    bus.out_ready = 1'b1;
    idle(2);
    check("reset_outputs",
          {bus.out_data, bus.out_valid, bus.out_last, bus.frame_ok, bus.frame_err, bus.err_code, bus.busy}, 0);
    rst = 1'b0;
    idle(2);

    // Good frame, first output together with frame_ok.
    clear_mon();
    send_list('{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33});
    send_byte(8'h03);
    check("good_first_valid", bus.out_valid, 1);
    check("good_first_ok", bus.frame_ok, 1);
    check("good_first_data", bus.out_data, 8'h11);
    wait_idle(1'b0);
    compare_model("good");
    check("good_errcode", bus.err_code, 0);

    // Garbage then frame.
    clear_mon();
    send_list('{8'h00, 8'hFF, 8'hA5, 8'h01, 8'h7E, 8'h7F});
    wait_idle(1'b0);
    compare_model("garbage");

    // Bad checksum.
    clear_mon();
    send_list('{8'hA5, 8'h02, 8'h10, 8'h20, 8'h00});
    check("badchk_busy", bus.busy, 0);
    check("badchk_code", bus.err_code, 1);
    wait_idle(1'b0);
    compare_model("badchk");

    // Bad lengths: zero and MAX_LEN+1.
    clear_mon();
    send_list('{8'hA5, 8'h00});
    check("badlen0_code", bus.err_code, 0);
    idle(2);
    send_list('{8'hA5, 8'h11});
    check("badlen17_err", bus.frame_err, 1);
    wait_idle(1'b0);
    compare_model("badlen");

    // Timeout after exactly TO idle cycles.
    clear_mon();
    send_list('{8'hA5, 8'h02, 8'hAA});
    hit = 0;
    for (int k = 1; k <= int'(TO) + 10 && hit == 0; k++) begin
      @(posedge clk);
      #1;
      if (bus.frame_err) hit = k;
    end
    check("timeout_cycles", hit, TO);
    check("timeout_code", bus.err_code, 2);
    check("timeout_busy", bus.busy, 0);
    idle(2);

    // Byte arriving on the expiry cycle wins.
    clear_mon();
    send_list('{8'hA5, 8'h01});
    idle(TO - 1);
    send_byte(8'h7E);
    send_byte(8'h7F);
    wait_idle(1'b0);
    compare_model("expiry_edge");

    // Overrun while stalled in emission.
    clear_mon();
    bus.out_ready = 1'b0;
    send_list('{8'hA5, 8'h02, 8'h5A, 8'hC3, 8'h9B});
    idle(2);
    send_byte(8'h44, 1'b0);
    idle(2);
    check("overrun_nerr", err_q.size(), 1);
    if (err_q.size() > 0) check("overrun_code", err_q[0], 3);
    check("overrun_no_xfer", got_d.size(), 0);
    check("overrun_valid", bus.out_valid, 1);
    err_q.delete();
    bus.out_ready = 1'b1;
    wait_idle(1'b0);
    compare_model("overrun");

    // Reset during emission.
    clear_mon();
    bus.out_ready = 1'b0;
    send_list('{8'hA5, 8'h01, 8'h33, 8'h32});
    idle(2);
    check("pre_reset_valid", bus.out_valid, 1);
    rst = 1'b1;
    #1;
    check("midreset_outputs",
          {bus.out_data, bus.out_valid, bus.out_last, bus.frame_ok, bus.frame_err, bus.err_code, bus.busy}, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.out_ready = 1'b1;
    idle(2);
    clear_mon();
    send_list('{8'hA5, 8'h02, 8'h01, 8'h02, 8'h01});
    wait_idle(1'b0);
    compare_model("post_reset");

    // Randomized chunks with random back-pressure.
    clear_mon();
    for (int c = 0; c < 30; c++) begin
      int unsigned kind = $urandom_range(0, 3);
      int unsigned len;
      logic [7:0]  x;
      fr.delete();
      case (kind)
        0, 1: begin
          len = $urandom_range(1, MAXL);
          x = 8'(len);
          fr.push_back(8'hA5);
          fr.push_back(8'(len));
          for (int unsigned i = 0; i < len; i++) begin
            fr.push_back(8'($urandom));
            x ^= fr[fr.size()-1];
          end
          if (kind == 1) x ^= 8'($urandom_range(1, 255));
          fr.push_back(x);
        end
        2: begin
          fr.push_back(8'hA5);
          fr.push_back(($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom_range(MAXL + 1, 255)));
        end
        default: begin
          for (int i = 0; i < int'($urandom_range(1, 4)); i++) begin
            x = 8'($urandom);
            if (x == 8'hA5) x = 8'h5A;
            fr.push_back(x);
          end
        end
      endcase
      foreach (fr[i]) begin
        send_byte(fr[i]);
        idle($urandom_range(0, 3));
      end
      wait_idle(1'b1);
    end
    compare_model("random");
    check("ok_err_exclusive", both_cnt, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/uart_rx_framer.md
# uart_rx_framer

Frame decoder that sits directly downstream of the UART receiver. It takes each received byte (`rx_data`/`rx_valid` pulse) and hunts for a sync byte, then collects a length-prefixed payload and checks it against an XOR checksum. The payload of each good frame is buffered and replayed as a valid/ready byte stream with a last marker. Bad, truncated or overrun frames are dropped and reported through an error pulse and code.

## Interface
- `MAX_LEN`, 16: maximum payload bytes per frame; legal range 1..255.
- `TIMEOUT_CYCLES`, 100000: idle cycles allowed between bytes inside a frame before it is aborted.
- `SYNC_BYTE`, 8'hA5: frame start marker.

Ports:
- `clk` input 1: system clock.
- `rst` input 1: reset, asynchronous, active-high.
- `rx_data` input 8: received byte, valid only when `rx_valid` is high.
- `rx_valid` input 1: single-cycle strobe, one per received byte.
- `out_data` output 8: payload byte.
- `out_valid` output 1: `out_data` is valid.
- `out_ready` input 1: consumer accepts the byte.
- `out_last` output 1: high with the final payload byte of a frame.
- `frame_ok` output 1: one-cycle pulse when a frame passes its checksum.
- `frame_err` output 1: one-cycle pulse when a frame is dropped.
- `err_code` output 2: cause of the most recent error; 0 bad length, 1 checksum, 2 timeout, 3 overrun. Holds its value until the next error.
- `busy` output 1: high in every state except S_SYNC.

## Operation
- Frame format on the wire: SYNC, LEN, LEN payload bytes, CHK.
- CHK must equal LEN XOR every payload byte.
- State machine: S_SYNC, S_LEN, S_PAYLOAD, S_CHK, S_EMIT.
- S_SYNC:
  - A byte equal to `SYNC_BYTE` moves to S_LEN.
  - Any other byte is discarded silently.
- S_LEN:
  - LEN of 0 or LEN > `MAX_LEN`: `frame_err`, code 0, return to S_SYNC.
  - Otherwise store LEN, seed the checksum with LEN, move to S_PAYLOAD.
- S_PAYLOAD:
  - Each byte is written to `buf[idx]`, XORed into the checksum, and `idx` increments.
  - After LEN bytes, move to S_CHK.
- S_CHK:
  - Match: `frame_ok` pulse, `idx` cleared, move to S_EMIT.
  - Mismatch: `frame_err`, code 1, return to S_SYNC.
- S_EMIT:
  - `out_valid`=1 and `out_data`=`buf[idx]`.
  - `idx` advances on each cycle with `out_valid && out_ready`.
  - `out_last` = (`idx` == LEN-1).
  - The transfer with `out_last` returns the block to S_SYNC.
- Overrun: an `rx_valid` while in S_EMIT drops that byte and pulses `frame_err` with code 3. Emission of the current frame continues.
- Timeout:
  - The counter clears on every accepted byte and counts only in S_LEN, S_PAYLOAD and S_CHK.
  - When it reaches `TIMEOUT_CYCLES`-1: `frame_err`, code 2, return to S_SYNC.
- Width rules:
  - `idx` and LEN are `$clog2(MAX_LEN+1)` bits.
  - The checksum is an 8-bit XOR with no carry.

## Timing
- Reset values: `out_data` 0, `out_valid` 0, `out_last` 0, `frame_ok` 0, `frame_err` 0, `err_code` 0, `busy` 0. State is S_SYNC, the checksum, `idx` and timeout counter are 0, buffer contents are don't-care.
- All decisions are registered on the `rx_valid` cycle. `frame_ok`, `frame_err` and state changes are visible on the next cycle.
- First `out_valid` appears on the cycle after the CHK byte's `rx_valid`, together with `frame_ok`.
- With `out_ready` held at 1, one byte is transferred per cycle. A frame of LEN bytes drains in LEN cycles.
- `out_data` and `out_last` stay stable while `out_valid && !out_ready`.
- If `rx_valid` and timeout expiry fall on the same cycle, the byte wins: it is accepted and the counter clears.
- Reset asserted mid-frame or mid-emission returns all outputs to their reset values immediately. The partial frame is lost.
- `frame_ok` and `frame_err` never assert in the same cycle.

## Structure
- Shared package `uart_frame_pkg` holds:
  - the state enum;
  - the error-code constants `ERR_LEN`, `ERR_CHK`, `ERR_TIMEOUT`, `ERR_OVERRUN`;
  - the default `SYNC_BYTE`.
- The payload buffer is an inline register array of `MAX_LEN` x 8. No sub-module.
- Timeout counter width: `$clog2(TIMEOUT_CYCLES)`.

## Test plan
- Good frame: bytes A5 03 11 22 33 03, `out_ready`=1.
  - `frame_ok` pulses once.
  - Output stream is 11, 22, 33, with `out_last` on 33.
  - `err_code` stays 0.
- Garbage then frame: 00 FF A5 01 7E 7F.
  - Leading bytes are ignored.
  - Single output byte 7E with `out_last`; `frame_ok` pulses.
- Bad checksum: A5 02 10 20 00.
  - `frame_err` with `err_code`=1.
  - No `out_valid`; back in S_SYNC with `busy`=0.
- Bad length with `MAX_LEN`=16:
  - A5 00 gives `frame_err` with code 0.
  - A5 11 gives `frame_err` with code 0.
- Timeout and overrun, two checks:
  - A5 02 AA, then idle for `TIMEOUT_CYCLES` cycles: `frame_err` with code 2.
  - Good frame with `out_ready`=0, plus an extra `rx_valid` during S_EMIT: `frame_err` with code 3; once `out_ready`=1 the original payload is delivered intact.
- Reset mid-emission: assert `rst` while `out_valid`=1.
  - All outputs are 0 in the same cycle.
  - After release, a new good frame decodes normally.
